// File: rtl/toy_mips_top.sv
// Minimal MIPS32-subset system: 5-stage core (ORI/ANDI/XORI/LUI) with
// forwarding into ID, plus a combinational-read instruction RAM.

module toy_mips_ram #(
    parameter int RAM_DEPTH = 1024
) (
    input  logic [29:0] addr,
    output logic [31:0] rdata
);
    localparam int AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

    // Contents are preloaded by the bench; hardware only reads.
    logic [31:0] memory [0:RAM_DEPTH-1];

    always_comb begin
        rdata = '0;
        if ({2'b00, addr} < 32'(RAM_DEPTH))
            rdata = memory[addr[AW-1:0]];
    end
endmodule

module toy_mips_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);
    logic [31:0] regs [0:31];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= '0;
        end else if (we && waddr != 5'd0) begin
            regs[waddr] <= wdata;
        end
    end

    // Write-first bypass lets WB feed an instruction currently in ID.
    always_comb begin
        rdata1 = regs[raddr1];
        if (raddr1 == 5'd0)
            rdata1 = '0;
        else if (we && waddr == raddr1)
            rdata1 = wdata;
    end

    always_comb begin
        rdata2 = regs[raddr2];
        if (raddr2 == 5'd0)
            rdata2 = '0;
        else if (we && waddr == raddr2)
            rdata2 = wdata;
    end
endmodule

module toy_mips_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    output logic [29:0] fetch_word
);
    typedef enum logic [1:0] {ALU_OR, ALU_AND, ALU_XOR, ALU_LUI} alu_e;

    function automatic logic [31:0] alu(alu_e sel, logic [31:0] a, logic [15:0] imm);
        case (sel)
            ALU_AND: return a & {16'h0, imm};
            ALU_XOR: return a ^ {16'h0, imm};
            ALU_LUI: return {imm, 16'h0};
            default: return a | {16'h0, imm};
        endcase
    endfunction

    logic [31:0] pc;
    logic [31:0] instr_p1;
    logic        vld_p2, vld_p3, vld_p4;
    logic [4:0]  rt_p2, rt_p3, rt_p4;
    alu_e        alu_p2;
    logic [31:0] rs_val_p2, res_p3, res_p4;
    logic [15:0] imm_p2;

    logic [5:0]  op;
    logic [4:0]  rs, rt;
    logic [15:0] imm;
    logic        dec_we;
    alu_e        dec_alu;
    logic [31:0] rf_rs, rt_val_unused, rs_fwd, res_ex;

    assign fetch_word = pc[31:2];

    // IF -> IF/ID
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            instr_p1 <= '0;
        end else begin
            pc       <= pc + 32'd4;
            instr_p1 <= instr;
        end
    end

    assign op  = instr_p1[31:26];
    assign rs  = instr_p1[25:21];
    assign rt  = instr_p1[20:16];
    assign imm = instr_p1[15:0];

    always_comb begin
        dec_we  = 1'b0;
        dec_alu = ALU_OR;
        case (op)
            6'b001101: begin dec_we = 1'b1; dec_alu = ALU_OR;  end
            6'b001100: begin dec_we = 1'b1; dec_alu = ALU_AND; end
            6'b001110: begin dec_we = 1'b1; dec_alu = ALU_XOR; end
            6'b001111: begin dec_we = 1'b1; dec_alu = ALU_LUI; end
            default:   ;
        endcase
    end

    toy_mips_regfile regfile (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (rs),
        .raddr2 (rt),
        .rdata1 (rf_rs),
        .rdata2 (rt_val_unused),
        .we     (vld_p4),
        .waddr  (rt_p4),
        .wdata  (res_p4)
    );

    // Youngest producer wins; $0 is never forwarded.
    always_comb begin
        rs_fwd = rf_rs;
        if (vld_p2 && rt_p2 == rs && rs != 5'd0)
            rs_fwd = res_ex;
        else if (vld_p3 && rt_p3 == rs && rs != 5'd0)
            rs_fwd = res_p3;
    end

    // ID -> ID/EX
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2    <= 1'b0;
            rt_p2     <= '0;
            alu_p2    <= ALU_OR;
            rs_val_p2 <= '0;
            imm_p2    <= '0;
        end else begin
            vld_p2    <= dec_we;
            rt_p2     <= rt;
            alu_p2    <= dec_alu;
            rs_val_p2 <= rs_fwd;
            imm_p2    <= imm;
        end
    end

    assign res_ex = alu(alu_p2, rs_val_p2, imm_p2);

    // EX -> EX/MEM -> MEM/WB
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p3 <= 1'b0;
            rt_p3  <= '0;
            res_p3 <= '0;
            vld_p4 <= 1'b0;
            rt_p4  <= '0;
            res_p4 <= '0;
        end else begin
            vld_p3 <= vld_p2;
            rt_p3  <= rt_p2;
            res_p3 <= res_ex;
            vld_p4 <= vld_p3;
            rt_p4  <= rt_p3;
            res_p4 <= res_p3;
        end
    end
endmodule

module toy_mips_top #(
    parameter int          RAM_DEPTH = 1024,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic clk,
    input  logic rst
);
    logic [29:0] fetch_word;
    logic [31:0] instr;

    toy_mips_ram #(.RAM_DEPTH(RAM_DEPTH)) ram (
        .addr  (fetch_word),
        .rdata (instr)
    );

    toy_mips_core #(.RESET_PC(RESET_PC)) openmips (
        .clk        (clk),
        .rst        (rst),
        .instr      (instr),
        .fetch_word (fetch_word)
    );
endmodule

// File: tb/tb_toy_mips_top.sv
// Directed bench for toy_mips_top: program table with expected register
// images, plus latency and mid-run reset sequences.

module tb_toy_mips_top;
    logic clk;
    logic rst;

    int total = 0;
    int passed = 0;

    toy_mips_top dut (
        .clk (clk),
        .rst (rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired passed=%0d total=%0d", passed, total);
        $fatal(1, "watchdog");
    end

    typedef struct {
        string             name;
        logic [3:0][31:0]  prog;
        logic [3:0][4:0]   rd;
        logic [3:0][31:0]  val;
    } vec_t;

    vec_t vecs [4];

    function automatic logic [31:0] enc(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                        logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_XORI = 6'b001110;
    localparam logic [5:0] OP_LUI  = 6'b001111;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        else
            passed++;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input logic [3:0][31:0] prog);
        for (int i = 0; i < 1024; i++)
            dut.ram.memory[i] = 32'h0;
        for (int i = 0; i < 4; i++)
            dut.ram.memory[i] = prog[i];
    endtask

    // Leaves rst low right after a rising edge, so the next edge is edge 1.
    task automatic start_prog(input logic [3:0][31:0] prog);
        rst = 1'b1;
        load(prog);
        tick(10);
        rst = 1'b0;
    endtask

    task automatic check_image(input string name, input vec_t v);
        logic [31:0] img [32];
        for (int i = 0; i < 32; i++)
            img[i] = 32'h0;
        for (int k = 0; k < 4; k++)
            img[v.rd[k]] = v.val[k];
        for (int i = 0; i < 32; i++)
            check($sformatf("%s_r%0d", name, i), dut.openmips.regfile.regs[i], img[i]);
    endtask

    initial begin
        rst = 1'b1;

        vecs[0].name = "ori4";
        vecs[0].prog[0] = enc(OP_ORI, 5'd0, 5'd1, 16'h1100);
        vecs[0].prog[1] = enc(OP_ORI, 5'd0, 5'd2, 16'h0020);
        vecs[0].prog[2] = enc(OP_ORI, 5'd0, 5'd3, 16'hff00);
        vecs[0].prog[3] = enc(OP_ORI, 5'd0, 5'd4, 16'hffff);
        vecs[0].rd  = {5'd4, 5'd3, 5'd2, 5'd1};
        vecs[0].val = {32'h0000ffff, 32'h0000ff00, 32'h00000020, 32'h00001100};

        vecs[1].name = "fwd";
        vecs[1].prog[0] = enc(OP_ORI,  5'd0, 5'd1, 16'h1100);
        vecs[1].prog[1] = enc(OP_ORI,  5'd1, 5'd1, 16'h0020);
        vecs[1].prog[2] = enc(OP_XORI, 5'd1, 5'd2, 16'h1120);
        vecs[1].prog[3] = enc(OP_ANDI, 5'd1, 5'd3, 16'h0100);
        vecs[1].rd  = {5'd3, 5'd2, 5'd1, 5'd1};
        vecs[1].val = {32'h00000100, 32'h00000000, 32'h00001120, 32'h00001120};

        vecs[2].name = "lui";
        vecs[2].prog[0] = enc(OP_LUI, 5'd0, 5'd5, 16'habcd);
        vecs[2].prog[1] = enc(OP_ORI, 5'd5, 5'd5, 16'h1234);
        vecs[2].prog[2] = enc(OP_ORI, 5'd0, 5'd0, 16'hffff);
        vecs[2].prog[3] = enc(OP_ORI, 5'd0, 5'd6, 16'h0000);
        vecs[2].rd  = {5'd5, 5'd6, 5'd0, 5'd5};
        vecs[2].val = {32'habcd1234, 32'h00000000, 32'h00000000, 32'habcd1234};

        vecs[3].name = "nop";
        vecs[3].prog[0] = enc(OP_ORI,     5'd0, 5'd7, 16'h0007);
        vecs[3].prog[1] = 32'h0000_0000;
        vecs[3].prog[2] = enc(6'b000010,  5'd0, 5'd8, 16'h0055);
        vecs[3].prog[3] = enc(OP_ORI,     5'd7, 5'd9, 16'h0100);
        vecs[3].rd  = {5'd7, 5'd9, 5'd8, 5'd7};
        vecs[3].val = {32'h00000007, 32'h00000107, 32'h00000000, 32'h00000007};

        // Reset state
        rst = 1'b1;
        load(vecs[0].prog);
        tick(10);
        check("rst_pc", dut.openmips.pc, 32'h0);
        check("rst_r1", dut.openmips.regfile.regs[1], 32'h0);
        check("rst_r31", dut.openmips.regfile.regs[31], 32'h0);
        check("rst_wb_vld", {31'h0, dut.openmips.vld_p4}, 32'h0);

        // Table-driven programs
        for (int v = 0; v < 4; v++) begin
            start_prog(vecs[v].prog);
            tick(100);
            check_image(vecs[v].name, vecs[v]);
        end

        // Latency
        start_prog(vecs[0].prog);
        tick(1);
        check("lat_pc_e1", dut.openmips.pc, 32'h4);
        tick(3);
        check("lat_r1_e4", dut.openmips.regfile.regs[1], 32'h0);
        tick(1);
        check("lat_r1_e5", dut.openmips.regfile.regs[1], 32'h00001100);
        tick(2);
        check("lat_r4_e7", dut.openmips.regfile.regs[4], 32'h0);
        tick(1);
        check("lat_r4_e8", dut.openmips.regfile.regs[4], 32'h0000ffff);

        // Mid-run reset after edge 6
        start_prog(vecs[0].prog);
        tick(6);
        check("mid_r2_e6", dut.openmips.regfile.regs[2], 32'h00000020);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("mid_pc", dut.openmips.pc, 32'h0);
        for (int i = 0; i < 32; i++)
            check($sformatf("mid_zero_r%0d", i), dut.openmips.regfile.regs[i], 32'h0);
        tick(1);
        check("mid_squash_r3", dut.openmips.regfile.regs[3], 32'h0);
        check("mid_squash_r4", dut.openmips.regfile.regs[4], 32'h0);
        tick(99);
        check_image("mid_rerun", vecs[0]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
